// File: rtl/cva6_shared_tlb_mp.sv
// Shared L2 TLB serving several requester TLBs through a round-robin arbiter.
// Each granted lookup is answered one cycle later; refills come from the PTW and flushes from SFENCE.VMA.
module cva6_shared_tlb_mp #(
  parameter int NUM_PORTS        = 2,
  parameter int SHARED_TLB_DEPTH = 64,
  parameter int SHARED_TLB_WAYS  = 2,
  parameter int PT_LEVELS        = 2,
  parameter int VPN_LEVEL_BITS   = 10,
  parameter int ASID_WIDTH       = 9,
  parameter int CONTENT_WIDTH    = 32,
  localparam int IDX_W   = $clog2(SHARED_TLB_DEPTH),
  localparam int WAY_W   = $clog2(SHARED_TLB_WAYS),
  localparam int LVL_W   = (PT_LEVELS > 2) ? $clog2(PT_LEVELS) : 1,
  localparam int VPN_LEN = PT_LEVELS * VPN_LEVEL_BITS,
  localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  input  logic [NUM_PORTS*VPN_LEN-1:0]    req_vpn_i,
  input  logic [NUM_PORTS*ASID_WIDTH-1:0] req_asid_i,
  output logic [NUM_PORTS-1:0]            resp_valid_o,
  output logic                            resp_hit_o,
  output logic [LVL_W-1:0]                resp_level_o,
  output logic                            resp_global_o,
  output logic [CONTENT_WIDTH-1:0]        resp_content_o,
  input  logic                            update_valid_i,
  input  logic [VPN_LEN-1:0]              update_vpn_i,
  input  logic [ASID_WIDTH-1:0]           update_asid_i,
  input  logic [LVL_W-1:0]                update_level_i,
  input  logic                            update_global_i,
  input  logic [CONTENT_WIDTH-1:0]        update_content_i,
  input  logic                            flush_i,
  input  logic [ASID_WIDTH-1:0]           flush_asid_i,
  input  logic [VPN_LEN-1:0]              flush_vpn_i,
  output logic                            flush_busy_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [SHARED_TLB_WAYS-1:0] valid_r   [SHARED_TLB_DEPTH];
  logic [VPN_LEN-1:0]         tag_r     [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
  logic [LVL_W-1:0]           lvl_r     [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
  logic                       glob_r    [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
  logic [ASID_WIDTH-1:0]      asid_r    [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
  logic [CONTENT_WIDTH-1:0]   content_r [SHARED_TLB_DEPTH][SHARED_TLB_WAYS];
  logic [WAY_W-1:0]           repl_ptr_r [SHARED_TLB_DEPTH];

  logic [0:0]            state_r;
  logic [IDX_W-1:0]      sweep_cnt_r;
  logic [ASID_WIDTH-1:0] sweep_asid_r;
  logic [PORT_W-1:0]     rr_ptr_r;

  logic [NUM_PORTS-1:0]     resp_valid_r;
  logic                     resp_hit_r;
  logic [LVL_W-1:0]         resp_level_r;
  logic                     resp_global_r;
  logic [CONTENT_WIDTH-1:0] resp_content_r;

  logic                       gnt_ok_s;
  logic [PORT_W-1:0]          gnt_idx_s;
  logic [NUM_PORTS-1:0]       grant_s;
  logic [VPN_LEN-1:0]         sel_vpn_s;
  logic [ASID_WIDTH-1:0]      sel_asid_s;
  logic [IDX_W-1:0]           lk_set_s;
  logic [SHARED_TLB_WAYS-1:0] hit_vec_s;
  logic [WAY_W-1:0]           hit_way_s;
  logic                       upd_en_s;
  logic [IDX_W-1:0]           up_set_s;
  logic [WAY_W-1:0]           inv_way_s;
  logic                       set_full_s;
  logic [WAY_W-1:0]           victim_s;
  logic                       flush_all_s;
  logic                       flush_vpn_nz_s;
  logic [IDX_W-1:0]           fl_set_s;
  logic [SHARED_TLB_WAYS-1:0] fl_clr_s;
  logic [SHARED_TLB_WAYS-1:0] sweep_clr_s;

  // Slices at or above the entry's level must agree; lower slices are the superpage offset.
  function automatic logic vpn_match(input logic [VPN_LEN-1:0] a, input logic [VPN_LEN-1:0] b,
                                     input logic [LVL_W-1:0] lvl);
    logic m;
    m = 1'b1;
    for (int l = 0; l < PT_LEVELS; l++) begin
      if ((l >= int'(lvl)) &&
          (a[l*VPN_LEVEL_BITS +: VPN_LEVEL_BITS] != b[l*VPN_LEVEL_BITS +: VPN_LEVEL_BITS])) begin
        m = 1'b0;
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= NUM_PORTS) ? PORT_W'(s - NUM_PORTS) : PORT_W'(s);
  endfunction

  // Round-robin arbitration starting at rr_ptr_r; descending scan leaves the nearest requester
  always_comb begin
    gnt_ok_s  = (state_r == IDLE) && !flush_i && !update_valid_i;
    gnt_idx_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      gnt_idx_s = req_valid_i[wrap_add(rr_ptr_r, i)] ? wrap_add(rr_ptr_r, i) : gnt_idx_s;
    end
    grant_s = (gnt_ok_s && (|req_valid_i)) ? (NUM_PORTS'(1'b1) << gnt_idx_s) : '0;
  end

  // Lookup of the granted request against the current array contents
  always_comb begin
    sel_vpn_s  = req_vpn_i[int'(gnt_idx_s)*VPN_LEN +: VPN_LEN];
    sel_asid_s = req_asid_i[int'(gnt_idx_s)*ASID_WIDTH +: ASID_WIDTH];
    lk_set_s   = sel_vpn_s[IDX_W-1:0];
    hit_vec_s  = '0;
    hit_way_s  = '0;
    for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
      hit_vec_s[w] = valid_r[lk_set_s][w] &&
                     ((asid_r[lk_set_s][w] == sel_asid_s) || glob_r[lk_set_s][w]) &&
                     vpn_match(tag_r[lk_set_s][w], sel_vpn_s, lvl_r[lk_set_s][w]);
    end
    for (int w = SHARED_TLB_WAYS - 1; w >= 0; w--) begin
      hit_way_s = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
    end
  end

  // Refill victim: lowest free way, otherwise the set's replacement pointer
  always_comb begin
    upd_en_s   = (state_r == IDLE) && !flush_i && update_valid_i;
    up_set_s   = update_vpn_i[IDX_W-1:0];
    set_full_s = &valid_r[up_set_s];
    inv_way_s  = '0;
    for (int w = SHARED_TLB_WAYS - 1; w >= 0; w--) begin
      inv_way_s = !valid_r[up_set_s][w] ? WAY_W'(w) : inv_way_s;
    end
    victim_s = set_full_s ? repl_ptr_r[up_set_s] : inv_way_s;
  end

  // Per-way clear masks for the targeted flush and for the current sweep set
  always_comb begin
    flush_all_s    = (flush_asid_i == '0) && (flush_vpn_i == '0);
    flush_vpn_nz_s = (flush_vpn_i != '0);
    fl_set_s       = flush_vpn_i[IDX_W-1:0];
    fl_clr_s       = '0;
    sweep_clr_s    = '0;
    for (int w = 0; w < SHARED_TLB_WAYS; w++) begin
      fl_clr_s[w] = vpn_match(tag_r[fl_set_s][w], flush_vpn_i, lvl_r[fl_set_s][w]) &&
                    ((flush_asid_i == '0) ||
                     ((asid_r[fl_set_s][w] == flush_asid_i) && !glob_r[fl_set_s][w]));
      sweep_clr_s[w] = !glob_r[sweep_cnt_r][w] && (asid_r[sweep_cnt_r][w] == sweep_asid_r);
    end
  end

  // Valid bits: sweep, flush and refill are mutually exclusive
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SHARED_TLB_DEPTH; s++) valid_r[s] <= '0;
    end else if (state_r == SWEEP) begin
      valid_r[sweep_cnt_r] <= valid_r[sweep_cnt_r] & ~sweep_clr_s;
    end else if (flush_i) begin
      if (flush_all_s) begin
        for (int s = 0; s < SHARED_TLB_DEPTH; s++) valid_r[s] <= '0;
      end else if (flush_vpn_nz_s) begin
        valid_r[fl_set_s] <= valid_r[fl_set_s] & ~fl_clr_s;
      end
    end else if (update_valid_i) begin
      valid_r[up_set_s][victim_s] <= 1'b1;
    end
  end

  // Entry payload write on refill
  always_ff @(posedge clk_i) begin
    if (upd_en_s) begin
      tag_r[up_set_s][victim_s]     <= update_vpn_i;
      lvl_r[up_set_s][victim_s]     <= update_level_i;
      glob_r[up_set_s][victim_s]    <= update_global_i;
      asid_r[up_set_s][victim_s]    <= update_asid_i;
      content_r[up_set_s][victim_s] <= update_content_i;
    end
  end

  // Per-set replacement pointer advances only when a full set is refilled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SHARED_TLB_DEPTH; s++) repl_ptr_r[s] <= '0;
    end else if (upd_en_s && set_full_s) begin
      repl_ptr_r[up_set_s] <= repl_ptr_r[up_set_s] + WAY_W'(1'b1);
    end
  end

  // ASID sweep FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      sweep_cnt_r  <= '0;
      sweep_asid_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush_i && !flush_vpn_nz_s && (flush_asid_i != '0)) begin
            state_r      <= SWEEP;
            sweep_cnt_r  <= '0;
            sweep_asid_r <= flush_asid_i;
          end
        end
        SWEEP: begin
          sweep_cnt_r <= sweep_cnt_r + IDX_W'(1'b1);
          if (sweep_cnt_r == {IDX_W{1'b1}}) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Arbiter pointer moves just past the port granted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= '0;
    end else if (|grant_s) begin
      rr_ptr_r <= wrap_add(gnt_idx_s, 1);
    end
  end

  // Response register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_r   <= '0;
      resp_hit_r     <= 1'b0;
      resp_level_r   <= '0;
      resp_global_r  <= 1'b0;
      resp_content_r <= '0;
    end else begin
      resp_valid_r <= grant_s;
      if ((|grant_s) && (|hit_vec_s)) begin
        resp_hit_r     <= 1'b1;
        resp_level_r   <= lvl_r[lk_set_s][hit_way_s];
        resp_global_r  <= glob_r[lk_set_s][hit_way_s];
        resp_content_r <= content_r[lk_set_s][hit_way_s];
      end else begin
        resp_hit_r     <= 1'b0;
        resp_level_r   <= '0;
        resp_global_r  <= 1'b0;
        resp_content_r <= '0;
      end
    end
  end

  assign req_ready_o    = grant_s;
  assign resp_valid_o   = resp_valid_r;
  assign resp_hit_o     = resp_hit_r;
  assign resp_level_o   = resp_level_r;
  assign resp_global_o  = resp_global_r;
  assign resp_content_o = resp_content_r;
  assign flush_busy_o   = (state_r == SWEEP);

endmodule

// File: tb/tb_cva6_shared_tlb_mp.sv
// Directed bench for cva6_shared_tlb_mp: a table of per-cycle vectors plus a reset-during-sweep sequence.
module tb_cva6_shared_tlb_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, resp_valid;
  logic [39:0] req_vpn;
  logic [17:0] req_asid;
  logic        resp_hit, resp_level, resp_global;
  logic [31:0] resp_content;
  logic        update_valid, update_level, update_global;
  logic [19:0] update_vpn;
  logic [8:0]  update_asid;
  logic [31:0] update_content;
  logic        flush;
  logic [8:0]  flush_asid;
  logic [19:0] flush_vpn;
  logic        flush_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  cva6_shared_tlb_mp dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_vpn_i(req_vpn), .req_asid_i(req_asid),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_level_o(resp_level),
    .resp_global_o(resp_global), .resp_content_o(resp_content),
    .update_valid_i(update_valid), .update_vpn_i(update_vpn), .update_asid_i(update_asid),
    .update_level_i(update_level), .update_global_i(update_global),
    .update_content_i(update_content),
    .flush_i(flush), .flush_asid_i(flush_asid), .flush_vpn_i(flush_vpn),
    .flush_busy_o(flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rep;
    logic [1:0]  rv;
    logic [19:0] vpn0, vpn1;
    logic [8:0]  asid0, asid1;
    logic        uv;
    logic [19:0] uvpn;
    logic [8:0]  uasid;
    logic        ulvl, uglb;
    logic [31:0] ucont;
    logic        fl;
    logic [8:0]  fasid;
    logic [19:0] fvpn;
    logic [1:0]  e_rdy, e_rv;
    logic        e_hit, e_lvl;
    logic [31:0] e_cont;
    logic        e_busy;
  } vec_t;

  vec_t q[$];

  function automatic vec_t rq(int rep, logic [1:0] rv, logic [19:0] v0, logic [8:0] a0,
                              logic [19:0] v1, logic [8:0] a1);
    vec_t v;
    v = '{rep: rep, rv: rv, vpn0: v0, vpn1: v1, asid0: a0, asid1: a1, uv: 1'b0, uvpn: 20'h0,
          uasid: 9'h0, ulvl: 1'b0, uglb: 1'b0, ucont: 32'h0, fl: 1'b0, fasid: 9'h0,
          fvpn: 20'h0, e_rdy: 2'b00, e_rv: 2'b00, e_hit: 1'b0, e_lvl: 1'b0, e_cont: 32'h0,
          e_busy: 1'b0};
    return v;
  endfunction

  function automatic vec_t idle();
    return rq(1, 2'b00, 20'h0, 9'h0, 20'h0, 9'h0);
  endfunction

  function automatic vec_t up(vec_t v, logic [19:0] vpn, logic [8:0] asid, logic lvl, logic glb,
                              logic [31:0] cont);
    vec_t r;
    r = v; r.uv = 1'b1; r.uvpn = vpn; r.uasid = asid; r.ulvl = lvl; r.uglb = glb; r.ucont = cont;
    return r;
  endfunction

  function automatic vec_t fl(vec_t v, logic [8:0] asid, logic [19:0] vpn);
    vec_t r;
    r = v; r.fl = 1'b1; r.fasid = asid; r.fvpn = vpn;
    return r;
  endfunction

  function automatic vec_t ex(vec_t v, logic [1:0] rdy, logic [1:0] rv, logic hit, logic lvl,
                              logic [31:0] cont, logic busy);
    vec_t r;
    r = v; r.e_rdy = rdy; r.e_rv = rv; r.e_hit = hit; r.e_lvl = lvl; r.e_cont = cont;
    r.e_busy = busy;
    return r;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(vec_t v);
    req_valid      = v.rv;
    req_vpn        = {v.vpn1, v.vpn0};
    req_asid       = {v.asid1, v.asid0};
    update_valid   = v.uv;
    update_vpn     = v.uvpn;
    update_asid    = v.uasid;
    update_level   = v.ulvl;
    update_global  = v.uglb;
    update_content = v.ucont;
    flush          = v.fl;
    flush_asid     = v.fasid;
    flush_vpn      = v.fvpn;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(idle());
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", -1, 32'(req_ready), 32'h0);
    chk("reset_resp_valid", -1, 32'(resp_valid), 32'h0);
    chk("reset_hit", -1, 32'(resp_hit), 32'h0);
    chk("reset_content", -1, resp_content, 32'h0);
    chk("reset_busy", -1, 32'(flush_busy), 32'h0);
    rst_n = 1'b1;

    // basic hit, superpage, ASID mismatch
    q.push_back(ex(idle(), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h00401, 9'd5, 1'b0, 1'b0, 32'hA5A5_0001), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h00440, 9'd3, 1'b1, 1'b0, 32'h0000_0440), 2'b00, 2'b01, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0));
    q.push_back(ex(rq(1, 2'b10, 20'h0, 9'd0, 20'h007C0, 9'd3), 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b10, 20'h0, 9'd0, 20'h007C0, 9'd4), 2'b10, 2'b10, 1'b1, 1'b1, 32'h0000_0440, 1'b0));
    // round robin with both ports requesting
    q.push_back(ex(rq(1, 2'b11, 20'h00401, 9'd5, 20'h00440, 9'd3), 2'b01, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b11, 20'h00401, 9'd5, 20'h00440, 9'd3), 2'b10, 2'b01, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0));
    q.push_back(ex(rq(1, 2'b11, 20'h00401, 9'd5, 20'h00440, 9'd3), 2'b01, 2'b10, 1'b1, 1'b1, 32'h0000_0440, 1'b0));
    q.push_back(ex(rq(1, 2'b11, 20'h00401, 9'd5, 20'h00440, 9'd3), 2'b10, 2'b01, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0));
    q.push_back(ex(idle(), 2'b00, 2'b10, 1'b1, 1'b1, 32'h0000_0440, 1'b0));
    // replacement in set 0x01 (already holding 0x00401 in way 0)
    q.push_back(ex(up(idle(), 20'h00001, 9'd1, 1'b0, 1'b0, 32'h0000_0101), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h00041, 9'd1, 1'b0, 1'b0, 32'h0000_0141), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h00081, 9'd1, 1'b0, 1'b0, 32'h0000_0181), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00001, 9'd1, 20'h0, 9'd0), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00041, 9'd1, 20'h0, 9'd0), 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b10, 20'h0, 9'd0, 20'h00081, 9'd1), 2'b10, 2'b01, 1'b1, 1'b0, 32'h0000_0141, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0), 2'b01, 2'b10, 1'b1, 1'b0, 32'h0000_0181, 1'b0));
    q.push_back(ex(idle(), 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    // update blocks a simultaneous request; pointer wrapped so way 0 is replaced
    q.push_back(ex(up(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0), 20'h00401, 9'd5, 1'b0, 1'b0, 32'hA5A5_0001), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00041, 9'd1, 20'h0, 9'd0), 2'b01, 2'b01, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0));
    q.push_back(ex(idle(), 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    // targeted flushes; response in flight survives the flush
    q.push_back(ex(fl(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0), 9'd0, 20'h00401), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00081, 9'd1, 20'h0, 9'd0), 2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(fl(idle(), 9'd1, 20'h00081), 2'b00, 2'b01, 1'b1, 1'b0, 32'h0000_0181, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00081, 9'd1, 20'h0, 9'd0), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(idle(), 2'b00, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    // ASID sweep
    q.push_back(ex(up(idle(), 20'h00800, 9'd7, 1'b0, 1'b0, 32'h0000_0700), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h00005, 9'd7, 1'b0, 1'b0, 32'h0000_0705), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h0003F, 9'd7, 1'b0, 1'b0, 32'h0000_073F), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(up(idle(), 20'h00045, 9'd2, 1'b0, 1'b1, 32'h0000_0745), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h00800, 9'd7, 20'h0, 9'd0), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b10, 20'h0, 9'd0, 20'h00045, 9'd7), 2'b10, 2'b01, 1'b1, 1'b0, 32'h0000_0700, 1'b0));
    q.push_back(ex(fl(idle(), 9'd7, 20'h0), 2'b00, 2'b10, 1'b1, 1'b0, 32'h0000_0745, 1'b0));
    q.push_back(ex(rq(64, 2'b11, 20'h00800, 9'd7, 20'h00005, 9'd7), 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1));
    q.push_back(ex(rq(1, 2'b11, 20'h00800, 9'd7, 20'h00005, 9'd7), 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b11, 20'h0003F, 9'd7, 20'h00045, 9'd7), 2'b10, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(rq(1, 2'b01, 20'h0003F, 9'd7, 20'h0, 9'd0), 2'b01, 2'b10, 1'b1, 1'b0, 32'h0000_0745, 1'b0));
    q.push_back(ex(rq(1, 2'b10, 20'h0, 9'd0, 20'h007C0, 9'd3), 2'b10, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0));
    q.push_back(ex(idle(), 2'b00, 2'b10, 1'b1, 1'b1, 32'h0000_0440, 1'b0));

    for (int i = 0; i < q.size(); i++) begin
      for (int r = 0; r < q[i].rep; r++) begin
        @(posedge clk);
        #1;
        drive(q[i]);
        @(negedge clk);
        chk("req_ready", i, 32'(req_ready), 32'(q[i].e_rdy));
        chk("resp_valid", i, 32'(resp_valid), 32'(q[i].e_rv));
        chk("flush_busy", i, 32'(flush_busy), 32'(q[i].e_busy));
        if (q[i].e_rv != 2'b00) chk("resp_hit", i, 32'(resp_hit), 32'(q[i].e_hit));
        if (q[i].e_rv != 2'b00 && q[i].e_hit) begin
          chk("resp_level", i, 32'(resp_level), 32'(q[i].e_lvl));
          chk("resp_content", i, resp_content, q[i].e_cont);
        end
      end
    end

    // reset asserted in the middle of an ASID sweep
    @(posedge clk); #1;
    drive(up(idle(), 20'h00401, 9'd5, 1'b0, 1'b0, 32'hA5A5_0001));
    @(posedge clk); #1;
    drive(fl(idle(), 9'd3, 20'h0));
    @(posedge clk); #1;
    drive(idle());
    repeat (5) @(posedge clk);
    #1;
    chk("sweep_busy_before_reset", 100, 32'(flush_busy), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("busy_after_reset", 101, 32'(flush_busy), 32'h0);
    chk("resp_valid_after_reset", 101, 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(rq(1, 2'b01, 20'h00401, 9'd5, 20'h0, 9'd0));
    @(negedge clk);
    chk("ready_after_reset", 102, 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    drive(rq(1, 2'b10, 20'h0, 9'd0, 20'h00045, 9'd7));
    @(negedge clk);
    chk("resp_valid_post_reset_a", 103, 32'(resp_valid), 32'h1);
    chk("hit_post_reset_a", 103, 32'(resp_hit), 32'h0);
    chk("busy_post_reset", 103, 32'(flush_busy), 32'h0);
    @(posedge clk); #1;
    drive(idle());
    @(negedge clk);
    chk("resp_valid_post_reset_b", 104, 32'(resp_valid), 32'h2);
    chk("hit_post_reset_b", 104, 32'(resp_hit), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cva6_shared_tlb_mp.md
Name: cva6_shared_tlb_mp

Overview:
- Next-generation shared L2 TLB between N requester TLBs (ITLB, DTLB, and optionally a second DTLB or PTW prefetcher) and the page-table walker.
- Parametrised in requester count, page-table levels, VPN slice width, depth and ways.
- Round-robin arbitration with valid/ready handshake and a one-cycle lookup pipeline.
- Supports superpages at any level, deterministic per-set replacement, and a multi-cycle ASID sweep flush FSM.

Parameters:
NUM_PORTS, 2, number of requester ports (>=1)
SHARED_TLB_DEPTH, 64, sets (power of two); IDX_W = log2(SHARED_TLB_DEPTH)
SHARED_TLB_WAYS, 2, ways per set (power of two, >=2); WAY_W = log2(SHARED_TLB_WAYS)
PT_LEVELS, 2, page-table levels (2 = Sv32, 3 = Sv39); LVL_W = log2(PT_LEVELS), minimum 1
VPN_LEVEL_BITS, 10, VPN bits per level; VPN_LEN = PT_LEVELS*VPN_LEVEL_BITS
ASID_WIDTH, 9, ASID width
CONTENT_WIDTH, 32, PTE payload width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_PORTS  lookup request per port
req_ready_o  out  NUM_PORTS  request accepted this cycle (grant)
req_vpn_i  in  NUM_PORTS*VPN_LEN  requested VPN per port
req_asid_i  in  NUM_PORTS*ASID_WIDTH  requesting ASID per port
resp_valid_o  out  NUM_PORTS  one-cycle response pulse to the port granted previous cycle
resp_hit_o  out  1  hit flag of the response
resp_level_o  out  LVL_W  page level of hit entry (0 = 4K)
resp_global_o  out  1  G bit of hit entry
resp_content_o  out  CONTENT_WIDTH  PTE of hit entry
update_valid_i  in  1  PTW refill
update_vpn_i  in  VPN_LEN  refill VPN
update_asid_i  in  ASID_WIDTH  refill ASID
update_level_i  in  LVL_W  refill page level
update_global_i  in  1  refill G bit
update_content_i  in  CONTENT_WIDTH  refill PTE
flush_i  in  1  SFENCE.VMA pulse
flush_asid_i  in  ASID_WIDTH  rs2 ASID
flush_vpn_i  in  VPN_LEN  rs1 VPN
flush_busy_o  out  1  ASID sweep in progress

Behaviour:
- Reset: all valid bits 0, replacement pointers 0, arbiter pointer 0, FSM IDLE; all outputs 0.
- Set index = update/req VPN[IDX_W-1:0]. Superpage entries live only in the set of the VPN that filled them.
- Hit condition (way w): valid, and (asid equal or global), and VPN slices at levels >= entry level equal. Slices below entry level are ignored.
- More than one way hitting is a fill error; lowest index wins.
- Arbitration, in IDLE with no flush_i and no update_valid_i:
  - Exactly one port is granted per cycle, round-robin starting after the last granted port.
  - req_ready_o[p] = grant[p]. Grant combinationally depends on req_valid_i only.
- Pipeline: request accepted in cycle t gives resp_valid_o[p] = 1 in cycle t+1 with hit/level/global/content. Content is don't-care when hit = 0.
  - Throughput: 1 request/cycle.
  - The response reflects array state at end of cycle t.
- Update:
  - update_valid_i blocks all grants that cycle.
  - Victim: lowest invalid way; if the set is full, the way at the set's round-robin pointer, which then increments (wraps at WAYS).
  - Writes tag, level, global, asid and content. Visible to requests accepted in cycle t+1.
- Flush, accepted only in IDLE. Blocks grants that cycle. Update in the same cycle is dropped.
  - asid=0, vpn=0: clear all valid bits at once.
  - vpn!=0: in set flush_vpn_i[IDX_W-1:0], clear ways whose VPN matches at entry level and (asid=0 or (asid match and !global)). Single cycle.
  - vpn=0, asid!=0: enter SWEEP with counter=0. Each cycle, clear non-global ways of set[counter] whose asid matches; counter++. Return to IDLE after set DEPTH-1 (DEPTH cycles).
  - flush_busy_o = (state==SWEEP).
- During SWEEP: no grants, updates ignored, flush_i ignored.
- A response for a request accepted the cycle before flush_i is still delivered, with pre-flush contents.
- Reset mid-sweep: immediate IDLE, all invalid.

Test Plan:
- Defaults. Update vpn=0x00401, asid=5, level=0, content=0xA5A5_0001; next cycle port0 req vpn=0x00401, asid=5 -> cycle+1 resp_valid_o=01, hit=1, content=0xA5A5_0001, level=0.
- Update vpn=0x00440, level=1, asid=3; req port1 vpn=0x007C0, asid=3 (same set 0x00, same VPN1 slice 0x001) -> hit=1, level=1. Req asid=4 with global=0 -> hit=0.
- Both ports hold valid for 4 cycles -> grants 01,10,01,10; responses follow 1 cycle later with matching resp_valid_o bits.
- Three updates to set 0x01 (vpn 0x001, 0x041, 0x081) -> ways 0,1 filled; third replaces way 0. Lookup 0x001 -> miss; 0x041 and 0x081 -> hit.
- Fill asid=7 entries in sets 0,5,63 plus a global entry in set 5; flush asid=7, vpn=0 -> flush_busy_o high exactly 64 cycles, req_ready_o=0 throughout. Afterwards only the global entry hits.
- Flush asid=0, vpn=0x00401 with matching entry -> that entry misses, others hit. Assert rst_ni low mid-sweep -> flush_busy_o=0, all lookups miss.
